// File: rtl/snoop_controller.sv
// Snoop path sequencer for one L1: accepts a coherence request, arbitrates for
// the shared state/tag RAM port 2, applies the MESI transition, fetches dirty
// data on M hits and returns the snoop response.
module snoop_controller #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned TAG_WIDTH    = 22,
  parameter int unsigned INDEX_WIDTH  = 6,
  parameter int unsigned OFFSET_WIDTH = 4,
  parameter int unsigned STATE_WIDTH  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   snp_valid,
  output logic                   snp_ready,
  input  logic [ADDR_WIDTH-1:0]  snp_addr,
  input  logic [1:0]             snp_type,
  output logic                   ram_req,
  input  logic                   ram_gnt,
  output logic [INDEX_WIDTH-1:0] ram_index,
  output logic [TAG_WIDTH-1:0]   tag_compare,
  input  logic                   chk_hit,
  input  logic [1:0]             chk_hit_way,
  input  logic [STATE_WIDTH-1:0] chk_hit_state,
  output logic                   state_tag_w_en,
  output logic [STATE_WIDTH-1:0] new_state,
  output logic                   dat_req,
  output logic [1:0]             dat_way,
  input  logic                   dat_ack,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_hit,
  output logic                   rsp_dirty,
  output logic                   rsp_shared
);

  localparam logic [STATE_WIDTH-1:0] ST_M = STATE_WIDTH'(3'b000);
  localparam logic [STATE_WIDTH-1:0] ST_S = STATE_WIDTH'(3'b010);
  localparam logic [STATE_WIDTH-1:0] ST_I = STATE_WIDTH'(3'b100);

  localparam logic [1:0] SNP_READ_UNIQUE = 2'd1;
  localparam logic [1:0] SNP_INVALIDATE  = 2'd2;

  typedef enum logic [2:0] {
    IDLE, ARB, LOOKUP, COMPARE, DATA, UPDATE, RESP
  } fsm_t;

  fsm_t state_q, state_d;

  // Transaction context latched at accept / compare time
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]             type_q, type_d;
  logic                   hit_q, hit_d;
  logic [1:0]             way_q, way_d;
  logic [STATE_WIDTH-1:0] cst_q, cst_d;

  logic [STATE_WIDTH-1:0] nxt_c;
  logic                   active_c;

  // Next values of the registered outputs
  logic                   snp_ready_d, ram_req_d, state_tag_w_en_d, dat_req_d;
  logic                   rsp_valid_d, rsp_hit_d, rsp_dirty_d, rsp_shared_d;
  logic [INDEX_WIDTH-1:0] ram_index_d;
  logic [TAG_WIDTH-1:0]   tag_compare_d;
  logic [STATE_WIDTH-1:0] new_state_d;
  logic [1:0]             dat_way_d;

  // Line offset bits never affect the snoop
  logic unused_offset;
  assign unused_offset = ^snp_addr[OFFSET_WIDTH-1:0];

  // Next-state, context capture and output decode
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    idx_d    = idx_q;
    type_d   = type_q;
    hit_d    = hit_q;
    way_d    = way_q;
    cst_d    = cst_q;
    nxt_c    = ST_S;
    active_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (snp_valid && snp_ready) begin
          state_d = ARB;
          tag_d   = snp_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
          idx_d   = snp_addr[OFFSET_WIDTH +: INDEX_WIDTH];
          type_d  = snp_type;
          hit_d   = 1'b0;
          way_d   = 2'b00;
          cst_d   = ST_I;
        end
      end
      ARB: begin
        if (ram_gnt) state_d = LOOKUP;
      end
      LOOKUP: state_d = COMPARE;
      COMPARE: begin
        // A way reported in I holds no line, so it is treated as a miss
        hit_d = chk_hit && (chk_hit_state != ST_I);
        way_d = chk_hit_way;
        cst_d = chk_hit_state;
        if (!hit_d)                                        state_d = RESP;
        else if (cst_d == ST_M && type_q != SNP_INVALIDATE) state_d = DATA;
        else                                               state_d = UPDATE;
      end
      DATA: begin
        if (dat_ack) state_d = UPDATE;
      end
      UPDATE: state_d = RESP;
      RESP: begin
        if (rsp_valid && rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Unique-ownership and invalidate snoops kill the line; everything else downgrades to S
    nxt_c = (type_d == SNP_READ_UNIQUE || type_d == SNP_INVALIDATE) ? ST_I : ST_S;

    // RAM port is locked from arbitration through the state write
    active_c = (state_d != IDLE) && (state_d != RESP);

    snp_ready_d      = (state_d == IDLE);
    ram_req_d        = active_c;
    ram_index_d      = active_c ? idx_d : INDEX_WIDTH'(0);
    tag_compare_d    = active_c ? tag_d : TAG_WIDTH'(0);
    dat_req_d        = (state_d == DATA);
    dat_way_d        = (state_d == DATA) ? way_d : 2'b00;
    state_tag_w_en_d = (state_d == UPDATE) && (nxt_c != cst_d);
    new_state_d      = (state_d == UPDATE) ? nxt_c : STATE_WIDTH'(0);
    rsp_valid_d      = (state_d == RESP);
    rsp_hit_d        = (state_d == RESP) && hit_d;
    rsp_dirty_d      = (state_d == RESP) && hit_d && (cst_d == ST_M) && (type_d != SNP_INVALIDATE);
    rsp_shared_d     = (state_d == RESP) && hit_d && (nxt_c == ST_S);
  end

  // State, context and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      tag_q          <= TAG_WIDTH'(0);
      idx_q          <= INDEX_WIDTH'(0);
      type_q         <= 2'b00;
      hit_q          <= 1'b0;
      way_q          <= 2'b00;
      cst_q          <= ST_I;
      snp_ready      <= 1'b0;
      ram_req        <= 1'b0;
      ram_index      <= INDEX_WIDTH'(0);
      tag_compare    <= TAG_WIDTH'(0);
      state_tag_w_en <= 1'b0;
      new_state      <= STATE_WIDTH'(0);
      dat_req        <= 1'b0;
      dat_way        <= 2'b00;
      rsp_valid      <= 1'b0;
      rsp_hit        <= 1'b0;
      rsp_dirty      <= 1'b0;
      rsp_shared     <= 1'b0;
    end else begin
      state_q        <= state_d;
      tag_q          <= tag_d;
      idx_q          <= idx_d;
      type_q         <= type_d;
      hit_q          <= hit_d;
      way_q          <= way_d;
      cst_q          <= cst_d;
      snp_ready      <= snp_ready_d;
      ram_req        <= ram_req_d;
      ram_index      <= ram_index_d;
      tag_compare    <= tag_compare_d;
      state_tag_w_en <= state_tag_w_en_d;
      new_state      <= new_state_d;
      dat_req        <= dat_req_d;
      dat_way        <= dat_way_d;
      rsp_valid      <= rsp_valid_d;
      rsp_hit        <= rsp_hit_d;
      rsp_dirty      <= rsp_dirty_d;
      rsp_shared     <= rsp_shared_d;
    end
  end

endmodule

// File: tb/tb_snoop_controller.sv
// Directed bench for snoop_controller: one task per scenario, inline checks.
module tb_snoop_controller;

  localparam logic [2:0] ST_M = 3'b000;
  localparam logic [2:0] ST_E = 3'b001;
  localparam logic [2:0] ST_S = 3'b010;
  localparam logic [2:0] ST_I = 3'b100;
  localparam logic [1:0] T_RS  = 2'd0;
  localparam logic [1:0] T_RU  = 2'd1;
  localparam logic [1:0] T_INV = 2'd2;

  logic        clk, rst;
  logic        snp_valid, snp_ready;
  logic [31:0] snp_addr;
  logic [1:0]  snp_type;
  logic        ram_req, ram_gnt;
  logic [5:0]  ram_index;
  logic [21:0] tag_compare;
  logic        chk_hit;
  logic [1:0]  chk_hit_way;
  logic [2:0]  chk_hit_state;
  logic        state_tag_w_en;
  logic [2:0]  new_state;
  logic        dat_req;
  logic [1:0]  dat_way;
  logic        dat_ack;
  logic        rsp_valid, rsp_ready, rsp_hit, rsp_dirty, rsp_shared;

  int checks = 0;
  int errors = 0;

  // Running count of write strobes and the state carried by the latest one
  int         wen_total = 0;
  logic [2:0] wen_state = 3'b000;

  logic [40:0] all_outs;
  assign all_outs = {snp_ready, ram_req, ram_index, tag_compare, state_tag_w_en, new_state,
                     dat_req, dat_way, rsp_valid, rsp_hit, rsp_dirty, rsp_shared};

  snoop_controller dut (
    .clk(clk), .rst(rst),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_addr(snp_addr), .snp_type(snp_type),
    .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_index(ram_index), .tag_compare(tag_compare),
    .chk_hit(chk_hit), .chk_hit_way(chk_hit_way), .chk_hit_state(chk_hit_state),
    .state_tag_w_en(state_tag_w_en), .new_state(new_state),
    .dat_req(dat_req), .dat_way(dat_way), .dat_ack(dat_ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_dirty(rsp_dirty), .rsp_shared(rsp_shared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe write strobes on the sampling edge
  always @(negedge clk) begin
    if (state_tag_w_en) begin
      wen_total = wen_total + 1;
      wen_state = new_state;
    end
  end

  // Hard stop if the sequence ever wedges
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Issue one snoop from IDLE and play RAM/checker/data side until rsp_valid
  task automatic run_txn(input logic [31:0] addr, input logic [1:0] typ, input logic hit,
                         input logic [1:0] way, input logic [2:0] cst,
                         input int gnt_delay, input int ack_delay,
                         output int lat, output int dcnt, output int way_bad,
                         output int req_drop, output logic acc,
                         output logic [21:0] tag_seen, output logic [5:0] idx_seen);
    int n;
    chk_hit = hit; chk_hit_way = way; chk_hit_state = cst;
    ram_gnt = 1'b0; dat_ack = 1'b0;
    dcnt = 0; way_bad = 0; n = 0;
    snp_valid = 1'b1; snp_addr = addr; snp_type = typ;
    @(negedge clk);
    snp_valid = 1'b0;
    acc = !snp_ready && ram_req;
    req_drop = ram_req ? 0 : 1;
    tag_seen = tag_compare;
    idx_seen = ram_index;
    while (!rsp_valid && n < 40) begin
      if (n == gnt_delay) ram_gnt = 1'b1;
      @(negedge clk);
      n = n + 1;
      dat_ack = 1'b0;
      if (n <= gnt_delay && !ram_req) req_drop = req_drop + 1;
      if (dat_req) begin
        dcnt = dcnt + 1;
        if (dat_way !== way) way_bad = way_bad + 1;
        if (dcnt == ack_delay + 1) dat_ack = 1'b1;
      end
    end
    ram_gnt = 1'b0;
    lat = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    snp_valid = 1'b0; snp_addr = 32'h0; snp_type = 2'd0;
    ram_gnt = 1'b0; chk_hit = 1'b0; chk_hit_way = 2'd0; chk_hit_state = ST_I;
    dat_ack = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (all_outs !== 41'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (snp_ready !== 1'b1 || rsp_valid !== 1'b0 || ram_req !== 1'b0) begin
      errors++; $display("FAIL reset_idle: snp_ready=%b rsp_valid=%b ram_req=%b expected 1/0/0",
                         snp_ready, rsp_valid, ram_req);
    end
  endtask

  task automatic test_read_shared_e();
    int lat, dcnt, wb, rd, wbase; logic acc; logic [21:0] tg; logic [5:0] ix;
    wbase = wen_total;
    run_txn(32'h1234_5670, T_RS, 1'b1, 2'd2, ST_E, 0, 0, lat, dcnt, wb, rd, acc, tg, ix);
    checks++;
    if (tg !== 22'h048D15 || ix !== 6'h27) begin
      errors++; $display("FAIL rs_e_addr: tag=%h idx=%h expected 048d15/27", tg, ix);
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL rs_e_latency: got %0d expected 4", lat); end
    checks++;
    if (wen_total - wbase !== 1 || wen_state !== ST_S) begin
      errors++; $display("FAIL rs_e_write: pulses=%0d state=%b expected 1/010", wen_total - wbase, wen_state);
    end
    checks++;
    if ({rsp_hit, rsp_dirty, rsp_shared} !== 3'b101 || dcnt !== 0 || ram_req !== 1'b0) begin
      errors++; $display("FAIL rs_e_rsp: hds=%b dat=%0d ram_req=%b expected 101/0/0",
                         {rsp_hit, rsp_dirty, rsp_shared}, dcnt, ram_req);
    end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || snp_ready !== 1'b1) begin
      errors++; $display("FAIL rs_e_handshake: rsp_valid=%b snp_ready=%b expected 0/1", rsp_valid, snp_ready);
    end
  endtask

  task automatic test_read_unique_m();
    int lat, dcnt, wb, rd, wbase; logic acc; logic [21:0] tg; logic [5:0] ix;
    wbase = wen_total;
    run_txn(32'h0000_ABC0, T_RU, 1'b1, 2'd1, ST_M, 0, 3, lat, dcnt, wb, rd, acc, tg, ix);
    checks++;
    if (dcnt !== 4 || wb !== 0) begin
      errors++; $display("FAIL ru_m_data: dat_req cycles=%0d bad_way=%0d expected 4/0", dcnt, wb);
    end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL ru_m_latency: got %0d expected 8", lat); end
    checks++;
    if (wen_total - wbase !== 1 || wen_state !== ST_I) begin
      errors++; $display("FAIL ru_m_write: pulses=%0d state=%b expected 1/100", wen_total - wbase, wen_state);
    end
    checks++;
    if ({rsp_hit, rsp_dirty, rsp_shared} !== 3'b110) begin
      errors++; $display("FAIL ru_m_rsp: got %b expected 110", {rsp_hit, rsp_dirty, rsp_shared});
    end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_miss();
    int lat, dcnt, wb, rd, wbase; logic acc; logic [21:0] tg; logic [5:0] ix;
    wbase = wen_total;
    run_txn(32'hFFFF_0010, T_RU, 1'b0, 2'd0, ST_I, 0, 0, lat, dcnt, wb, rd, acc, tg, ix);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL miss_latency: got %0d expected 3", lat); end
    checks++;
    if (dcnt !== 0 || wen_total - wbase !== 0) begin
      errors++; $display("FAIL miss_side_effects: dat=%0d wen=%0d expected 0/0", dcnt, wen_total - wbase);
    end
    checks++;
    if ({rsp_valid, rsp_hit, rsp_dirty, rsp_shared} !== 4'b1000) begin
      errors++; $display("FAIL miss_rsp: got %b expected 1000", {rsp_valid, rsp_hit, rsp_dirty, rsp_shared});
    end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_gnt_delay();
    int lat, dcnt, wb, rd, wbase; logic acc; logic [21:0] tg; logic [5:0] ix;
    wbase = wen_total;
    run_txn(32'h8000_0400, T_RS, 1'b1, 2'd0, ST_S, 5, 0, lat, dcnt, wb, rd, acc, tg, ix);
    checks++;
    if (rd !== 0) begin errors++; $display("FAIL gnt_req_held: drops=%0d expected 0", rd); end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL gnt_latency: got %0d expected 9", lat); end
    checks++;
    if (wen_total - wbase !== 0) begin
      errors++; $display("FAIL gnt_no_write: pulses=%0d expected 0", wen_total - wbase);
    end
    checks++;
    if ({rsp_hit, rsp_dirty, rsp_shared} !== 3'b101) begin
      errors++; $display("FAIL gnt_rsp: got %b expected 101", {rsp_hit, rsp_dirty, rsp_shared});
    end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat, dcnt, wb, rd, wbase; logic acc; logic [21:0] tg; logic [5:0] ix;
    wbase = wen_total;
    run_txn(32'h0F0F_0F00, T_RS, 1'b1, 2'd3, ST_M, 0, 0, lat, dcnt, wb, rd, acc, tg, ix);
    checks++;
    if (lat !== 5 || dcnt !== 1 || wb !== 0) begin
      errors++; $display("FAIL b2b_first: lat=%0d dat=%0d bad_way=%0d expected 5/1/0", lat, dcnt, wb);
    end
    checks++;
    if (wen_total - wbase !== 1 || wen_state !== ST_S) begin
      errors++; $display("FAIL b2b_first_write: pulses=%0d state=%b expected 1/010", wen_total - wbase, wen_state);
    end
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_hit, rsp_dirty, rsp_shared} !== 4'b1111 || snp_ready !== 1'b0) begin
        errors++; $display("FAIL b2b_stall_%0d: rsp=%b snp_ready=%b expected 1111/0",
                           i, {rsp_valid, rsp_hit, rsp_dirty, rsp_shared}, snp_ready);
      end
    end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    checks++;
    if (snp_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_release: snp_ready=%b rsp_valid=%b expected 1/0", snp_ready, rsp_valid);
    end
    wbase = wen_total;
    run_txn(32'h0F0F_0F00, T_INV, 1'b1, 2'd0, ST_M, 0, 0, lat, dcnt, wb, rd, acc, tg, ix);
    checks++;
    if (acc !== 1'b1 || lat !== 4 || dcnt !== 0) begin
      errors++; $display("FAIL b2b_inv: accepted=%b lat=%0d dat=%0d expected 1/4/0", acc, lat, dcnt);
    end
    checks++;
    if (wen_total - wbase !== 1 || wen_state !== ST_I) begin
      errors++; $display("FAIL b2b_inv_write: pulses=%0d state=%b expected 1/100", wen_total - wbase, wen_state);
    end
    checks++;
    if ({rsp_hit, rsp_dirty, rsp_shared} !== 3'b100) begin
      errors++; $display("FAIL b2b_inv_rsp: got %b expected 100", {rsp_hit, rsp_dirty, rsp_shared});
    end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_data();
    int n, wbase;
    n = 0;
    chk_hit = 1'b1; chk_hit_way = 2'd1; chk_hit_state = ST_M;
    ram_gnt = 1'b1; dat_ack = 1'b0;
    snp_valid = 1'b1; snp_addr = 32'h5555_5550; snp_type = T_RU;
    @(negedge clk);
    snp_valid = 1'b0;
    while (!dat_req && n < 20) begin @(negedge clk); n = n + 1; end
    checks++;
    if (dat_req !== 1'b1) begin errors++; $display("FAIL rstmid_reach_data: dat_req=%b expected 1", dat_req); end
    wbase = wen_total;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs !== 41'd0) begin errors++; $display("FAIL rstmid_outputs: got %h expected 0", all_outs); end
    @(negedge clk);
    rst = 1'b0; ram_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if (snp_ready !== 1'b1 || ram_req !== 1'b0 || dat_req !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: ready=%b req=%b dat=%b rsp=%b expected 1/0/0/0",
                         snp_ready, ram_req, dat_req, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (wen_total - wbase !== 0) begin
      errors++; $display("FAIL rstmid_no_write: pulses=%0d expected 0", wen_total - wbase);
    end
  endtask

  initial begin
    test_reset();
    test_read_shared_e();
    test_read_unique_m();
    test_miss();
    test_gnt_delay();
    test_back_to_back();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
